// File: rtl/fetch_wf_arbiter.sv
// fetch_wf_arbiter
// ----------------
// Round-robin arbiter that chooses which wavefront slot issues the next
// instruction fetch. A slot is eligible when it is allocated (wf_active) and
// not throttled by the wave queue pool (stop_fetch). Once a slot is picked,
// the request is held until the fetch unit acknowledges it. The next search
// then starts one slot above the granted one. A granted handshake produces a
// one-cycle, one-hot q_vtail_incr pulse in the following cycle.
//
// Handshake: fetch_valid/fetch_wf_id are registered and stay stable while
// fetch_valid=1. The transfer happens on a rising edge where fetch_valid=1 and
// fetch_ack=1. fetch_ack is ignored while fetch_valid=0. The arbiter always
// spends one IDLE cycle after a transfer, so at most one grant is made every
// two cycles.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   An 8-bit watchdog abandons a request after 256 consecutive REQ cycles
//   without fetch_ack. An abandoned request produces no pulse, advances the
//   pointer past the slot, and sets the sticky timeout_err flag. When the
//   macro is undefined, there is no watchdog and timeout_err is tied to 0.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   wf_active     in   [NUM_WF] slot allocated
//   stop_fetch    in   [NUM_WF] slot throttled (not eligible)
//   fetch_ack     in   fetch unit accepts the pending request
//   fetch_valid   out  request pending (FSM in REQ)
//   fetch_wf_id   out  [6] slot of the pending request
//   q_vtail_incr  out  [NUM_WF] one-hot pulse for the granted slot
//   timeout_err   out  sticky watchdog flag
//   dbg_state     out  current FSM state (0=IDLE, 1=REQ)
module fetch_wf_arbiter #(
  parameter int NUM_WF = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] wf_active,
  input  logic [NUM_WF-1:0] stop_fetch,
  input  logic              fetch_ack,
  output logic              fetch_valid,
  output logic [5:0]        fetch_wf_id,
  output logic [NUM_WF-1:0] q_vtail_incr,
  output logic              timeout_err,
  output logic              dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [5:0]        rr_ptr_q, rr_ptr_d;
  logic [5:0]        wf_id_q, wf_id_d;
  logic [NUM_WF-1:0] vtail_q, vtail_d;

  logic [NUM_WF-1:0] eligible;
  logic              pick_found;
  logic [5:0]        pick_idx;
  logic [5:0]        wf_id_next;
  logic              wdog_fire;

  assign eligible = wf_active & ~stop_fetch;

  // Pointer value after the current slot is retired (39 wraps to 0).
  assign wf_id_next = (wf_id_q == 6'(NUM_WF - 1)) ? 6'd0 : wf_id_q + 6'd1;

  // First eligible slot at or above rr_ptr, wrapping past the top slot.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = 6'd0;
    idx        = 0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_WF) idx = idx - NUM_WF;
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 6'(idx);
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_err_q;

  // The counter holds the number of REQ cycles already spent without an ack.
  // The 256th such cycle is the one where the counter reads 255.
  assign wdog_fire = (state_q == ST_REQ) && !fetch_ack && (wdog_q == 8'hFF);
  // Any IDLE cycle clears the counter, so every entry to REQ starts at zero.
  assign wdog_d    = ((state_q == ST_REQ) && !fetch_ack) ? wdog_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q        <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_q | wdog_fire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wdog_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wf_id_d  = wf_id_q;
    vtail_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_REQ;
          wf_id_d = pick_idx;
        end
      end
      ST_REQ: begin
        // The request is held regardless of eligibility changes until it
        // is acknowledged (or abandoned by the watchdog).
        if (fetch_ack) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wf_id_next;
          vtail_d  = {{(NUM_WF-1){1'b0}}, 1'b1} << wf_id_q;
        end else if (wdog_fire) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wf_id_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 6'd0;
      wf_id_q  <= 6'd0;
      vtail_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wf_id_q  <= wf_id_d;
      vtail_q  <= vtail_d;
    end
  end

  assign fetch_valid  = (state_q == ST_REQ);
  assign fetch_wf_id  = wf_id_q;
  assign q_vtail_incr = vtail_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_wf_arbiter.sv
// Testbench for fetch_wf_arbiter. Expected grants are pushed to exp_q when
// stimulus is applied and are popped when the DUT presents the request.
// Inputs change away from rising edges, and outputs are sampled on falling edges.
module tb_fetch_wf_arbiter;
  localparam int N = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] wf_active;
  logic [N-1:0] stop_fetch;
  logic         fetch_ack;
  logic         fetch_valid;
  logic [5:0]   fetch_wf_id;
  logic [N-1:0] q_vtail_incr;
  logic         timeout_err;
  logic         dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [5:0] exp_q[$];

  fetch_wf_arbiter #(.NUM_WF(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .wf_active    (wf_active),
    .stop_fetch   (stop_fetch),
    .fetch_ack    (fetch_ack),
    .fetch_valid  (fetch_valid),
    .fetch_wf_id  (fetch_wf_id),
    .q_vtail_incr (q_vtail_incr),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [N-1:0] onehot(input logic [5:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // driver: reset, ends at a falling edge in IDLE with rr_ptr=0
  task automatic do_reset();
    rst = 1'b1; wf_active = '0; stop_fetch = '0; fetch_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wf_active = '1; stop_fetch = '0; fetch_ack = 1'b1;
    #1;
    total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", fetch_valid); else pass_cnt++;
    total_cnt++; if (fetch_wf_id !== 6'd0) $display("FAIL reset_id: got %0d expected 0", fetch_wf_id); else pass_cnt++;
    total_cnt++; if (q_vtail_incr !== '0) $display("FAIL reset_vtail: got %h expected 0", q_vtail_incr); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); else pass_cnt++;
    total_cnt++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b expected 0", dbg_state); else pass_cnt++;
  endtask

  // All slots eligible, ack always high: grants 0..39 then 0, with a bubble between grants.
  task automatic test_round_robin();
    logic [N-1:0] exp_vt;
    logic         prev_valid;
    logic [5:0]   e;
    int           cyc;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(6'(i));
    exp_q.push_back(6'd0);
    wf_active = '1; fetch_ack = 1'b1;
    exp_vt = '0; prev_valid = 1'b0; cyc = 0;
    while ((exp_q.size() > 0 || exp_vt != '0) && cyc < 200) begin
      @(negedge clk); cyc++;
      total_cnt++;
      if (q_vtail_incr !== exp_vt) $display("FAIL rr_vtail: got %h expected %h", q_vtail_incr, exp_vt); else pass_cnt++;
      exp_vt = '0;
      if (prev_valid) begin
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL rr_bubble: got valid %b expected 0", fetch_valid); else pass_cnt++;
      end
      if (fetch_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (fetch_wf_id !== e) $display("FAIL rr_grant: got %0d expected %0d", fetch_wf_id, e); else pass_cnt++;
        exp_vt = onehot(e);
      end
      prev_valid = (fetch_valid === 1'b1);
    end
    wf_active = '0; fetch_ack = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rr_timeout: got %0d grants pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  // Slots 5 and 38 only: 5 first (pointer -> 6), then 38, then wrap to 5.
  task automatic test_wrap();
    logic [5:0] e;
    int         cyc;
    do_reset();
    exp_q.delete();
    exp_q.push_back(6'd5); exp_q.push_back(6'd38); exp_q.push_back(6'd5);
    wf_active = onehot(6'd5) | onehot(6'd38); fetch_ack = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (fetch_valid === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (fetch_wf_id !== e) $display("FAIL wrap_grant: got %0d expected %0d", fetch_wf_id, e); else pass_cnt++;
        @(negedge clk); cyc++;
        total_cnt++;
        if (q_vtail_incr !== onehot(e)) $display("FAIL wrap_vtail: got %h expected %h", q_vtail_incr, onehot(e)); else pass_cnt++;
      end
    end
    wf_active = '0; fetch_ack = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL wrap_timeout: got %0d grants pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  // Ack in IDLE is ignored; stop_fetch masks slots.
  task automatic test_idle_ack_and_mask();
    logic [5:0] e;
    do_reset();
    exp_q.delete();
    fetch_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL idle_ack_valid: got %b expected 0", fetch_valid); else pass_cnt++;
      total_cnt++; if (q_vtail_incr !== '0) $display("FAIL idle_ack_vtail: got %h expected 0", q_vtail_incr); else pass_cnt++;
    end
    wf_active = '1; stop_fetch = '1;
    repeat (3) begin
      @(negedge clk);
      total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL mask_all_valid: got %b expected 0", fetch_valid); else pass_cnt++;
    end
    fetch_ack = 1'b0;
    stop_fetch = ~onehot(6'd20);
    exp_q.push_back(6'd20);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL mask_valid: got %b expected 1", fetch_valid); else pass_cnt++;
    total_cnt++; if (fetch_wf_id !== e) $display("FAIL mask_grant: got %0d expected %0d", fetch_wf_id, e); else pass_cnt++;
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0; wf_active = '0; stop_fetch = '0;
    total_cnt++; if (q_vtail_incr !== onehot(e)) $display("FAIL mask_vtail: got %h expected %h", q_vtail_incr, onehot(e)); else pass_cnt++;
  endtask

  // Slot 7 held for 10 cycles without ack while it loses eligibility.
  task automatic test_hold();
    logic [5:0] e;
    do_reset();
    exp_q.delete();
    wf_active = onehot(6'd7); fetch_ack = 1'b0;
    exp_q.push_back(6'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) stop_fetch = onehot(6'd7);
      if (c == 4) wf_active = '0;
      total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL hold_valid: cycle %0d got %b expected 1", c, fetch_valid); else pass_cnt++;
      total_cnt++; if (fetch_wf_id !== exp_q[0]) $display("FAIL hold_id: cycle %0d got %0d expected %0d", c, fetch_wf_id, exp_q[0]); else pass_cnt++;
    end
    @(negedge clk);
    fetch_ack = 1'b1;
    total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL hold_valid11: got %b expected 1", fetch_valid); else pass_cnt++;
    @(negedge clk);
    fetch_ack = 1'b0;
    e = exp_q.pop_front();
    total_cnt++; if (q_vtail_incr !== onehot(e)) $display("FAIL hold_vtail: got %h expected %h", q_vtail_incr, onehot(e)); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL hold_bubble: got %b expected 0", fetch_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (q_vtail_incr !== '0) $display("FAIL hold_vtail_single: got %h expected 0", q_vtail_incr); else pass_cnt++;
    stop_fetch = '0;
  endtask

  // Reset during REQ on slot 12 drops the request at once; restart from slot 0.
  task automatic test_reset_mid_req();
    logic [5:0] e;
    do_reset();
    exp_q.delete();
    wf_active = onehot(6'd12); fetch_ack = 1'b0;
    exp_q.push_back(6'd12);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (fetch_wf_id !== e || fetch_valid !== 1'b1) $display("FAIL rstmid_grant: got %0d/%b expected %0d/1", fetch_wf_id, fetch_valid, e); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", fetch_valid); else pass_cnt++;
    wf_active = '1; fetch_ack = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (q_vtail_incr !== '0) $display("FAIL rstmid_vtail: got %h expected 0", q_vtail_incr); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(6'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL rstmid_regrant_valid: got %b expected 1", fetch_valid); else pass_cnt++;
    total_cnt++; if (fetch_wf_id !== e) $display("FAIL rstmid_regrant_id: got %0d expected %0d", fetch_wf_id, e); else pass_cnt++;
    @(negedge clk);
    wf_active = '0; fetch_ack = 1'b0;
    total_cnt++; if (q_vtail_incr !== onehot(e)) $display("FAIL rstmid_regrant_vtail: got %h expected %h", q_vtail_incr, onehot(e)); else pass_cnt++;
  endtask

  // Slot 3 never acknowledged: watchdog behaviour or indefinite wait.
  task automatic test_timeout();
    logic [5:0] e;
    do_reset();
    exp_q.delete();
    wf_active = onehot(6'd3); fetch_ack = 1'b0;
    exp_q.push_back(6'd3);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (fetch_valid !== 1'b1 || fetch_wf_id !== e) $display("FAIL to_grant: got %0d/%b expected %0d/1", fetch_wf_id, fetch_valid, e); else pass_cnt++;
    wf_active = '1;
`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      n = 1;
      while (n < 300) begin
        @(negedge clk);
        if (fetch_valid !== 1'b1) break;
        n++;
      end
      total_cnt++; if (n !== 256) $display("FAIL to_cycles: got %0d expected 256", n); else pass_cnt++;
      total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL to_drop: got %b expected 0", fetch_valid); else pass_cnt++;
      total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b expected 1", timeout_err); else pass_cnt++;
      total_cnt++; if (q_vtail_incr !== '0) $display("FAIL to_vtail: got %h expected 0", q_vtail_incr); else pass_cnt++;
      exp_q.push_back(6'd4);
      @(negedge clk);
      e = exp_q.pop_front();
      total_cnt++; if (fetch_valid !== 1'b1 || fetch_wf_id !== e) $display("FAIL to_next_grant: got %0d/%b expected %0d/1", fetch_wf_id, fetch_valid, e); else pass_cnt++;
      fetch_ack = 1'b1;
      @(negedge clk);
      total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_err_sticky: got %b expected 1", timeout_err); else pass_cnt++;
    end
`else
    repeat (1000) @(negedge clk);
    total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL nto_valid: got %b expected 1", fetch_valid); else pass_cnt++;
    total_cnt++; if (fetch_wf_id !== e) $display("FAIL nto_id: got %0d expected %0d", fetch_wf_id, e); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL nto_err: got %b expected 0", timeout_err); else pass_cnt++;
`endif
    wf_active = '0; fetch_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_idle_ack_and_mask();
    test_hold();
    test_reset_mid_req();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_wf_arbiter.md
FETCH_WF_ARBITER -- requirements
Module: fetch_wf_arbiter

Interface
REQ-001 Parameter NUM_WF, default 40: wavefront slot count; SHALL match the wave queue pool depth and is fixed at 40.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port wf_active  input  40  bit i high = wavefront slot i is allocated.
REQ-005 Port stop_fetch  input  40  per-slot fetch throttle from the wave queue pool; high = slot i is not eligible.
REQ-006 Port fetch_ack  input  1  instruction-fetch unit accepts the current request this cycle.
REQ-007 Port fetch_valid  output  1  a fetch request is pending.
REQ-008 Port fetch_wf_id  output  6  slot index of the pending request, range 0..39.
REQ-009 Port q_vtail_incr  output  40  one-hot pulse to the wave queue pool; advances the virtual tail of the granted slot.
REQ-010 Port timeout_err  output  1  sticky flag; request abandoned by the watchdog (see Configuration).

Function
REQ-011 Eligibility SHALL be eligible[i] = wf_active[i] & ~stop_fetch[i].
REQ-012 FSM states SHALL be IDLE and REQ only.
REQ-013 IDLE, any eligible bit set: SHALL pick the first eligible slot searching upward from rr_ptr, wrapping 39->0, and move to REQ.
REQ-014 IDLE, no eligible bit: SHALL stay in IDLE with fetch_valid=0.
REQ-015 Latency: eligible seen in cycle N -> fetch_valid=1 with the chosen fetch_wf_id registered in cycle N+1.
REQ-016 In REQ, fetch_valid SHALL stay 1 and fetch_wf_id SHALL stay stable until fetch_ack, even if that slot's stop_fetch or wf_active deasserts meanwhile.
REQ-017 REQ with fetch_ack=1 (handshake) SHALL:
  - return to IDLE;
  - set rr_ptr = (fetch_wf_id+1) mod 40, so 39 wraps to 0;
  - assert q_vtail_incr[fetch_wf_id] for exactly one cycle in the following cycle.
REQ-018 fetch_ack while in IDLE SHALL be ignored.
REQ-019 Throughput SHALL be at most one grant per two cycles; there is a mandatory IDLE bubble after each handshake.
REQ-020 q_vtail_incr SHALL be all-zero in every cycle not covered by REQ-017 and never have more than one bit set.
REQ-021 fetch_wf_id SHALL hold its last value while in IDLE; its value is don't-care whenever fetch_valid=0.

Reset
REQ-022 rst high SHALL asynchronously force:
  - state=IDLE, rr_ptr=0;
  - fetch_valid=0, fetch_wf_id=0;
  - q_vtail_incr=0, timeout_err=0;
  - watchdog counter=0.
REQ-023 Reset asserted in REQ SHALL drop the pending request immediately with no q_vtail_incr pulse; arbitration restarts at slot 0 on the first edge after release.

Configuration
REQ-024 Macro FETCH_TIMEOUT_EN defined:
  - an 8-bit watchdog counts consecutive REQ cycles without fetch_ack;
  - on the 256th such cycle: return to IDLE, no q_vtail_incr pulse, rr_ptr = fetch_wf_id+1 mod 40, timeout_err set;
  - timeout_err stays set until rst;
  - the counter clears on every entry to REQ.
REQ-025 Macro FETCH_TIMEOUT_EN undefined: no watchdog logic; timeout_err tied to 0; a request waits indefinitely for fetch_ack.

Verification
REQ-026 After reset, wf_active=all ones, stop_fetch=0, fetch_ack always 1 -> grants 0,1,2,...,39,0 on alternate cycles, each followed next cycle by the matching one-hot q_vtail_incr pulse.
REQ-027 wf_active bits 5 and 38 only, rr_ptr=6 -> grant 38; after its handshake -> grant 5 (wrap-around).
REQ-028 Grant slot 7, fetch_ack held 0 for 10 cycles while stop_fetch[7] rises -> fetch_valid=1 and fetch_wf_id=7 held all 10 cycles; ack on cycle 11 -> q_vtail_incr[7] pulse.
REQ-029 rst asserted mid-REQ on slot 12 -> same-cycle fetch_valid=0, no pulse; after release with all slots eligible -> first grant slot 0.
REQ-030 FETCH_TIMEOUT_EN defined, slot 3 granted, fetch_ack=0 for 256 cycles -> fetch_valid drops, timeout_err=1, next grant is the first eligible slot from 4; macro undefined -> request still pending after 1000 cycles, timeout_err=0.
